// File: rtl/insdec_mt.sv
// Instruction-decode/register stage for a multithreaded pipeline: per-thread register files,
// RAW/WAW scoreboard and a registered valid/ready handoff to execute. Option: INSDEC_MT_BYPASS_EN.
module insdec_mt #(
  parameter int DATA_W   = 32,
  parameter int NUM_TRD  = 8,
  parameter int NUM_REG  = 32,
  parameter int CTRL_W   = 32,
  parameter int INIT_REG = 1,
  parameter int TRD_W    = $clog2(NUM_TRD),
  parameter int REG_W    = $clog2(NUM_REG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_id,
  output logic              ready_id,
  input  logic [31:0]       ins_id,
  input  logic [31:0]       pc_id,
  input  logic [TRD_W-1:0]  trd_id,
  input  logic [REG_W-1:0]  rd_a_id,
  input  logic [REG_W-1:0]  rd_b_id,
  input  logic [REG_W-1:0]  wr_reg_id,
  input  logic              use_a_id,
  input  logic              use_b_id,
  input  logic              wr_en_id,
  input  logic [CTRL_W-1:0] ctrl_id,
  input  logic              wr_en_wb,
  input  logic [TRD_W-1:0]  wr_trd_wb,
  input  logic [REG_W-1:0]  wr_reg_wb,
  input  logic [DATA_W-1:0] data_wb,
  input  logic              init_en,
  input  logic [TRD_W-1:0]  init_trd,
  input  logic [DATA_W-1:0] init_data,
  input  logic              flush_en,
  input  logic [TRD_W-1:0]  flush_trd,
  output logic              valid_exe,
  input  logic              ready_exe,
  output logic [DATA_W-1:0] data_a_exe,
  output logic [DATA_W-1:0] data_b_exe,
  output logic [31:0]       pc_exe,
  output logic [31:0]       ins_exe,
  output logic [TRD_W-1:0]  trd_exe,
  output logic [REG_W-1:0]  reg_wr_exe,
  output logic              wr_en_exe,
  output logic [CTRL_W-1:0] ctrl_exe,
  output logic              hazard_id
);

  localparam logic [REG_W-1:0] INIT_IDX = REG_W'(INIT_REG);

  logic [DATA_W-1:0]  rf_q   [NUM_TRD][NUM_REG];
  logic [NUM_REG-1:0] busy_q [NUM_TRD];
  logic [NUM_REG-1:0] busy_d [NUM_TRD];

  logic              vld_q;
  logic [DATA_W-1:0] data_a_q, data_b_q;
  logic [31:0]       pc_q, ins_q;
  logic [TRD_W-1:0]  trd_q;
  logic [REG_W-1:0]  reg_wr_q;
  logic              wr_en_q;
  logic [CTRL_W-1:0] ctrl_q;

  logic               flush_exe, handoff, accept, id_flush, wb_blocked;
  logic [NUM_REG-1:0] pend_vec;
  logic [DATA_W-1:0]  op_a, op_b;

  // A flushed exe entry disappears combinationally so it can never be handed off
  assign flush_exe  = flush_en & (trd_q == flush_trd);
  assign valid_exe  = vld_q & ~flush_exe;
  assign handoff    = valid_exe & ready_exe;
  assign id_flush   = flush_en & (flush_trd == trd_id);

  assign data_a_exe = data_a_q;
  assign data_b_exe = data_b_q;
  assign pc_exe     = pc_q;
  assign ins_exe    = ins_q;
  assign trd_exe    = trd_q;
  assign reg_wr_exe = reg_wr_q;
  assign wr_en_exe  = wr_en_q;
  assign ctrl_exe   = ctrl_q;

  always_comb begin
    pend_vec = busy_q[trd_id];
`ifdef INSDEC_MT_BYPASS_EN
    if (wr_en_wb && (wr_trd_wb == trd_id)) pend_vec[wr_reg_wb] = 1'b0;
`endif
    if (valid_exe && wr_en_q && (trd_q == trd_id)) pend_vec[reg_wr_q] = 1'b1;
    pend_vec[0] = 1'b0;
  end

  assign hazard_id = valid_id & ((use_a_id & pend_vec[rd_a_id]) |
                                 (use_b_id & pend_vec[rd_b_id]) |
                                 (wr_en_id & pend_vec[wr_reg_id]));
  assign ready_id  = ~hazard_id & (~valid_exe | ready_exe);
  assign accept    = valid_id & ready_id;

  always_comb begin
    op_a = rf_q[trd_id][rd_a_id];
    op_b = rf_q[trd_id][rd_b_id];
`ifdef INSDEC_MT_BYPASS_EN
    if (wr_en_wb && (wr_trd_wb == trd_id) && (wr_reg_wb == rd_a_id)) op_a = data_wb;
    if (wr_en_wb && (wr_trd_wb == trd_id) && (wr_reg_wb == rd_b_id)) op_b = data_wb;
`endif
    if (!use_a_id || (rd_a_id == '0)) op_a = '0;
    if (!use_b_id || (rd_b_id == '0)) op_b = '0;
  end

  // Set beats clear so an instruction handed off in the same cycle keeps its reservation
  always_comb begin
    busy_d = busy_q;
    if (init_en) busy_d[init_trd] = '0;
    if (wr_en_wb) busy_d[wr_trd_wb][wr_reg_wb] = 1'b0;
    if (handoff && wr_en_q && (reg_wr_q != '0)) busy_d[trd_q][reg_wr_q] = 1'b1;
  end

  assign wb_blocked = init_en & (init_trd == wr_trd_wb) & (wr_reg_wb == INIT_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NUM_TRD; t++) begin
        busy_q[t] <= '0;
        for (int r = 0; r < NUM_REG; r++) rf_q[t][r] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      if (wr_en_wb && (wr_reg_wb != '0) && !wb_blocked) rf_q[wr_trd_wb][wr_reg_wb] <= data_wb;
      if (init_en && (INIT_IDX != '0)) rf_q[init_trd][INIT_IDX] <= init_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= 1'b0;
      data_a_q <= '0;
      data_b_q <= '0;
      pc_q     <= '0;
      ins_q    <= '0;
      trd_q    <= '0;
      reg_wr_q <= '0;
      wr_en_q  <= 1'b0;
      ctrl_q   <= '0;
    end else if (accept) begin
      vld_q    <= ~id_flush;
      data_a_q <= op_a;
      data_b_q <= op_b;
      pc_q     <= pc_id;
      ins_q    <= ins_id;
      trd_q    <= trd_id;
      reg_wr_q <= wr_reg_id;
      wr_en_q  <= wr_en_id;
      ctrl_q   <= ctrl_id;
    end else if (handoff || flush_exe) begin
      vld_q    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_insdec_mt.sv
// Randomised and directed bench for insdec_mt against a behavioural model of the
// register files, scoreboard and exe register.
module tb_insdec_mt;
  localparam int NT = 8;
  localparam int NR = 32;
`ifdef INSDEC_MT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_id, ready_id;
  logic [31:0] ins_id, pc_id;
  logic [2:0]  trd_id;
  logic [4:0]  rd_a_id, rd_b_id, wr_reg_id;
  logic        use_a_id, use_b_id, wr_en_id;
  logic [31:0] ctrl_id;
  logic        wr_en_wb;
  logic [2:0]  wr_trd_wb;
  logic [4:0]  wr_reg_wb;
  logic [31:0] data_wb;
  logic        init_en;
  logic [2:0]  init_trd;
  logic [31:0] init_data;
  logic        flush_en;
  logic [2:0]  flush_trd;
  logic        valid_exe, ready_exe;
  logic [31:0] data_a_exe, data_b_exe, pc_exe, ins_exe, ctrl_exe;
  logic [2:0]  trd_exe;
  logic [4:0]  reg_wr_exe;
  logic        wr_en_exe, hazard_id;

  always #5 clk = ~clk;

  insdec_mt dut (
    .clk(clk), .rst_n(rst_n),
    .valid_id(valid_id), .ready_id(ready_id), .ins_id(ins_id), .pc_id(pc_id),
    .trd_id(trd_id), .rd_a_id(rd_a_id), .rd_b_id(rd_b_id), .wr_reg_id(wr_reg_id),
    .use_a_id(use_a_id), .use_b_id(use_b_id), .wr_en_id(wr_en_id), .ctrl_id(ctrl_id),
    .wr_en_wb(wr_en_wb), .wr_trd_wb(wr_trd_wb), .wr_reg_wb(wr_reg_wb), .data_wb(data_wb),
    .init_en(init_en), .init_trd(init_trd), .init_data(init_data),
    .flush_en(flush_en), .flush_trd(flush_trd),
    .valid_exe(valid_exe), .ready_exe(ready_exe),
    .data_a_exe(data_a_exe), .data_b_exe(data_b_exe), .pc_exe(pc_exe), .ins_exe(ins_exe),
    .trd_exe(trd_exe), .reg_wr_exe(reg_wr_exe), .wr_en_exe(wr_en_exe), .ctrl_exe(ctrl_exe),
    .hazard_id(hazard_id)
  );

  // Reference state
  logic [31:0] m_rf [NT][NR];
  bit          m_busy [NT][NR];
  bit          e_vld, e_wen;
  logic [31:0] e_a, e_b, e_pc, e_ins, e_ctrl;
  logic [2:0]  e_trd;
  logic [4:0]  e_rd;
  int          infl[$];
  int          errors = 0;
  int          checks = 0;
  logic        obs_rdy, obs_haz, obs_vld;
  logic [31:0] pa, pb;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < NT; t++)
      for (int r = 0; r < NR; r++) begin
        m_rf[t][r] = '0;
        m_busy[t][r] = 1'b0;
      end
    e_vld = 0; e_wen = 0; e_a = 0; e_b = 0; e_pc = 0; e_ins = 0; e_ctrl = 0;
    e_trd = 0; e_rd = 0;
    infl.delete();
  endtask

  function automatic bit m_pend(input logic [2:0] t, input logic [4:0] r, input bit gv);
    if (r == 0) return 1'b0;
    if (gv && e_wen && e_trd == t && e_rd == r) return 1'b1;
    if (m_busy[t][r] && !(BYP && wr_en_wb && wr_trd_wb == t && wr_reg_wb == r)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] t, input logic [4:0] r, input logic u);
    if (!u || r == 0) return 32'h0;
    if (BYP && wr_en_wb && wr_trd_wb == t && wr_reg_wb == r) return data_wb;
    return m_rf[t][r];
  endfunction

  // One clock: check outputs against the model at the falling edge, then advance the model.
  task automatic step();
    bit gv, haz, rdy, acc, ho;
    logic [31:0] na, nb;
    @(negedge clk);
    gv  = e_vld && !(flush_en && flush_trd == e_trd);
    haz = valid_id && ((use_a_id && m_pend(trd_id, rd_a_id, gv)) ||
                       (use_b_id && m_pend(trd_id, rd_b_id, gv)) ||
                       (wr_en_id && m_pend(trd_id, wr_reg_id, gv)));
    rdy = !haz && (!gv || ready_exe);
    acc = valid_id && rdy;
    ho  = gv && ready_exe;
    obs_rdy = ready_id; obs_haz = hazard_id; obs_vld = valid_exe;
    check("ready_id",   64'(ready_id),   64'(rdy));
    check("hazard_id",  64'(hazard_id),  64'(haz));
    check("valid_exe",  64'(valid_exe),  64'(gv));
    check("data_a_exe", 64'(data_a_exe), 64'(e_a));
    check("data_b_exe", 64'(data_b_exe), 64'(e_b));
    check("pc_exe",     64'(pc_exe),     64'(e_pc));
    check("ins_exe",    64'(ins_exe),    64'(e_ins));
    check("trd_exe",    64'(trd_exe),    64'(e_trd));
    check("reg_wr_exe", 64'(reg_wr_exe), 64'(e_rd));
    check("wr_en_exe",  64'(wr_en_exe),  64'(e_wen));
    check("ctrl_exe",   64'(ctrl_exe),   64'(e_ctrl));
    na = m_read(trd_id, rd_a_id, use_a_id);
    nb = m_read(trd_id, rd_b_id, use_b_id);
    if (init_en) for (int r = 0; r < NR; r++) m_busy[init_trd][r] = 1'b0;
    if (wr_en_wb) m_busy[wr_trd_wb][wr_reg_wb] = 1'b0;
    if (ho && e_wen && e_rd != 0) begin
      m_busy[e_trd][e_rd] = 1'b1;
      infl.push_back(int'(e_trd) * NR + int'(e_rd));
    end
    if (wr_en_wb && wr_reg_wb != 0 && !(init_en && init_trd == wr_trd_wb && wr_reg_wb == 5'd1))
      m_rf[wr_trd_wb][wr_reg_wb] = data_wb;
    if (init_en) m_rf[init_trd][1] = init_data;
    if (acc) begin
      e_vld = !(flush_en && flush_trd == trd_id);
      e_a = na; e_b = nb; e_pc = pc_id; e_ins = ins_id; e_ctrl = ctrl_id;
      e_trd = trd_id; e_rd = wr_reg_id; e_wen = wr_en_id;
    end else if (ho || (flush_en && flush_trd == e_trd)) begin
      e_vld = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_id = 0; use_a_id = 0; use_b_id = 0; wr_en_id = 0;
    trd_id = 0; rd_a_id = 0; rd_b_id = 0; wr_reg_id = 0;
    ins_id = 0; pc_id = 0; ctrl_id = 0;
    ready_exe = 1; wr_en_wb = 0; wr_trd_wb = 0; wr_reg_wb = 0; data_wb = 0;
    init_en = 0; init_trd = 0; init_data = 0; flush_en = 0; flush_trd = 0;
  endtask

  task automatic issue(input int t, input int ra, input bit ua, input int rb, input bit ub,
                       input int wr, input bit we);
    valid_id = 1; trd_id = 3'(t);
    rd_a_id = 5'(ra); use_a_id = ua; rd_b_id = 5'(rb); use_b_id = ub;
    wr_reg_id = 5'(wr); wr_en_id = we;
    pc_id = $urandom; ins_id = $urandom; ctrl_id = $urandom;
  endtask

  task automatic wb(input int t, input int r, input logic [31:0] d);
    wr_en_wb = 1; wr_trd_wb = 3'(t); wr_reg_wb = 5'(r); data_wb = d;
  endtask

  task automatic rand_cycle();
    int idx, e;
    valid_id  = ($urandom_range(0, 9) < 7);
    trd_id    = 3'($urandom_range(0, 3));
    rd_a_id   = 5'($urandom_range(0, 7));
    rd_b_id   = 5'($urandom_range(0, 7));
    wr_reg_id = 5'($urandom_range(0, 7));
    use_a_id  = 1'($urandom_range(0, 1));
    use_b_id  = 1'($urandom_range(0, 1));
    wr_en_id  = 1'($urandom_range(0, 1));
    pc_id = $urandom; ins_id = $urandom; ctrl_id = $urandom;
    ready_exe = ($urandom_range(0, 3) != 0);
    wr_en_wb = 0;
    data_wb = $urandom;
    if (infl.size() > 0 && $urandom_range(0, 2) == 0) begin
      idx = $urandom_range(0, infl.size() - 1);
      e = infl[idx];
      infl.delete(idx);
      wr_en_wb = 1; wr_trd_wb = 3'(e / NR); wr_reg_wb = 5'(e % NR);
    end else if ($urandom_range(0, 19) == 0) begin
      wr_en_wb = 1; wr_trd_wb = 3'($urandom_range(0, 3)); wr_reg_wb = 5'($urandom_range(0, 7));
    end
    init_en = ($urandom_range(0, 49) == 0);
    init_trd = 3'($urandom_range(0, 3));
    init_data = $urandom;
    flush_en = ($urandom_range(0, 19) == 0);
    flush_trd = 3'($urandom_range(0, 3));
  endtask

  initial begin
    idle();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_exe",  64'(valid_exe),  64'(0));
    check("rst_hazard_id",  64'(hazard_id),  64'(0));
    check("rst_data_a_exe", 64'(data_a_exe), 64'(0));
    check("rst_ctrl_exe",   64'(ctrl_exe),   64'(0));
    check("rst_ready_id",   64'(ready_id),   64'(1));
    rst_n = 1;

    // Write-back then read
    idle(); wb(3, 5, 32'h1234); step();
    idle(); issue(3, 5, 1, 0, 0, 0, 0); step();
    check("r5_read", 64'(data_a_exe), 64'h1234);
    idle(); wb(3, 0, 32'hFFFF_FFFF); step();
    idle(); issue(3, 0, 1, 5, 1, 0, 0); step();
    check("r0_read", 64'(data_a_exe), 64'h0);
    check("r5_b_read", 64'(data_b_exe), 64'h1234);

    // RAW on thread 2 r7
    idle(); issue(2, 0, 0, 0, 0, 7, 1); step();
    idle(); step();
    idle(); issue(2, 7, 1, 0, 0, 0, 0); step();
    check("raw_haz", 64'(obs_haz), 64'(1));
    check("raw_rdy", 64'(obs_rdy), 64'(0));
    step();
    check("raw_hold", 64'(obs_rdy), 64'(0));
    wb(2, 7, 32'hAA); step();
    if (BYP) begin
      check("raw_wb_rdy", 64'(obs_rdy), 64'(1));
    end else begin
      check("raw_wb_rdy", 64'(obs_rdy), 64'(0));
      wr_en_wb = 0; step();
      check("raw_late_rdy", 64'(obs_rdy), 64'(1));
    end
    check("raw_data", 64'(data_a_exe), 64'hAA);

    // Cross-thread independence
    idle(); issue(2, 0, 0, 0, 0, 7, 1); step();
    idle(); step();
    idle(); issue(4, 7, 1, 0, 0, 0, 0); step();
    check("xthr_haz", 64'(obs_haz), 64'(0));
    check("xthr_rdy", 64'(obs_rdy), 64'(1));
    idle(); wb(2, 7, 32'h55); step();
    idle(); step();

    // Backpressure
    idle(); issue(5, 1, 1, 2, 1, 0, 0); ready_exe = 0; pa = pc_id; step();
    issue(5, 3, 1, 0, 0, 0, 0); ready_exe = 0; pb = pc_id;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_rdy", 64'(obs_rdy), 64'(0));
      check("bp_vld", 64'(obs_vld), 64'(1));
      check("bp_pc", 64'(pc_exe), 64'(pa));
    end
    ready_exe = 1; step();
    check("bp_rel_rdy", 64'(obs_rdy), 64'(1));
    check("bp_next_pc", 64'(pc_exe), 64'(pb));

    // Flush of thread 1 in exe
    idle(); issue(1, 0, 0, 0, 0, 9, 1); step();
    idle(); flush_en = 1; flush_trd = 1; step();
    check("fl_vld", 64'(obs_vld), 64'(0));
    idle(); issue(1, 9, 1, 0, 0, 0, 0); step();
    check("fl_nobusy", 64'(obs_haz), 64'(0));

    // Init of thread 6 while r3 is busy
    idle(); issue(6, 0, 0, 0, 0, 3, 1); step();
    idle(); step();
    idle(); issue(6, 3, 1, 0, 0, 0, 0); step();
    check("init_pre_haz", 64'(obs_haz), 64'(1));
    init_en = 1; init_trd = 6; init_data = 32'h8000; step();
    check("init_cyc_haz", 64'(obs_haz), 64'(1));
    init_en = 0; step();
    check("init_rdy", 64'(obs_rdy), 64'(1));
    idle(); issue(6, 1, 1, 0, 0, 0, 0); step();
    check("init_data", 64'(data_a_exe), 64'h8000);
    idle(); step();
    infl.delete();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      rand_cycle();
      step();
    end

    // Reset mid-operation
    rst_n = 0;
    #1;
    check("midrst_vld", 64'(valid_exe), 64'(0));
    check("midrst_a",   64'(data_a_exe), 64'(0));
    model_reset();
    idle();
    @(posedge clk);
    #1;
    rst_n = 1;
    for (int c = 0; c < 300; c++) begin
      rand_cycle();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
